// File: rtl/execute_stage_reg.sv
// Decode->Execute pipeline register, operand forwarding and ARM flags/condition unit.
// Optional: define EXECUTE_BUBBLE_COUNT_EN to add the BubbleCountE flush counter.
module execute_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             MemtoRegD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic [1:0]       ALUControlD,
  input  logic [1:0]       FlagWriteD,
  input  logic [3:0]       CondD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [3:0]       ALUFlags,
  output logic [3:0]       RA1E,
  output logic [3:0]       RA2E,
  output logic [3:0]       WA3E,
  output logic             MemtoRegE,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [1:0]       ALUControlE,
  output logic             CondExE,
  output logic             RegWriteGE,
  output logic             MemWriteGE,
  output logic             PCSrcGE,
  output logic             BranchTakenE,
  output logic [3:0]       FlagsE
`ifdef EXECUTE_BUBBLE_COUNT_EN
  ,
  output logic [31:0]      BubbleCountE
`endif
);

  logic [WIDTH-1:0] rd1E;
  logic [WIDTH-1:0] rd2E;
  logic [WIDTH-1:0] extImmE;
  logic             regWriteE;
  logic             memWriteE;
  logic             aluSrcE;
  logic             branchE;
  logic             pcSrcE;
  logic [1:0]       flagWriteE;
  logic [3:0]       condE;

  logic flagN;
  logic flagZ;
  logic flagC;
  logic flagV;

  assign flagN = FlagsE[3];
  assign flagZ = FlagsE[2];
  assign flagC = FlagsE[1];
  assign flagV = FlagsE[0];

  // D->E register; a flush loads a bubble whose condition never passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1E        <= '0;
      rd2E        <= '0;
      extImmE     <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      regWriteE   <= 1'b0;
      memWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      aluSrcE     <= 1'b0;
      branchE     <= 1'b0;
      pcSrcE      <= 1'b0;
      ALUControlE <= '0;
      flagWriteE  <= '0;
      condE       <= '0;
    end else if (FlushE) begin
      rd1E        <= '0;
      rd2E        <= '0;
      extImmE     <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      regWriteE   <= 1'b0;
      memWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      aluSrcE     <= 1'b0;
      branchE     <= 1'b0;
      pcSrcE      <= 1'b0;
      ALUControlE <= '0;
      flagWriteE  <= '0;
      condE       <= 4'hF;
    end else begin
      rd1E        <= RD1D;
      rd2E        <= RD2D;
      extImmE     <= ExtImmD;
      RA1E        <= RA1D;
      RA2E        <= RA2D;
      WA3E        <= WA3D;
      regWriteE   <= RegWriteD;
      memWriteE   <= MemWriteD;
      MemtoRegE   <= MemtoRegD;
      aluSrcE     <= ALUSrcD;
      branchE     <= BranchD;
      pcSrcE      <= PCSrcD;
      ALUControlE <= ALUControlD;
      flagWriteE  <= FlagWriteD;
      condE       <= CondD;
    end
  end

  // Operand forwarding from Memory and Writeback
  always_comb begin
    SrcAE = rd1E;
    case (ForwardAE)
      2'b01:   SrcAE = ResultW;
      2'b10:   SrcAE = ALUResultM;
      default: SrcAE = rd1E;
    endcase
    WriteDataE = rd2E;
    case (ForwardBE)
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUResultM;
      default: WriteDataE = rd2E;
    endcase
    SrcBE = aluSrcE ? extImmE : WriteDataE;
  end

  // Condition evaluation against flags as they stand before this op
  always_comb begin
    CondExE = 1'b0;
    unique case (condE)
      4'h0: CondExE = flagZ;
      4'h1: CondExE = !flagZ;
      4'h2: CondExE = flagC;
      4'h3: CondExE = !flagC;
      4'h4: CondExE = flagN;
      4'h5: CondExE = !flagN;
      4'h6: CondExE = flagV;
      4'h7: CondExE = !flagV;
      4'h8: CondExE = flagC && !flagZ;
      4'h9: CondExE = !flagC || flagZ;
      4'hA: CondExE = (flagN == flagV);
      4'hB: CondExE = (flagN != flagV);
      4'hC: CondExE = !flagZ && (flagN == flagV);
      4'hD: CondExE = flagZ || (flagN != flagV);
      4'hE: CondExE = 1'b1;
      4'hF: CondExE = 1'b0;
    endcase
  end

  // Side effects only happen when the condition passes
  always_comb begin
    RegWriteGE   = regWriteE & CondExE;
    MemWriteGE   = memWriteE & CondExE;
    PCSrcGE      = pcSrcE & CondExE;
    BranchTakenE = branchE & CondExE;
  end

  // NZ and CV halves update independently when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlagsE <= '0;
    end else if (CondExE) begin
      if (flagWriteE[1]) FlagsE[3:2] <= ALUFlags[3:2];
      if (flagWriteE[0]) FlagsE[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef EXECUTE_BUBBLE_COUNT_EN
  // Saturating count of flushed cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BubbleCountE <= '0;
    end else if (FlushE && (BubbleCountE != 32'hFFFF_FFFF)) begin
      BubbleCountE <= BubbleCountE + 32'd1;
    end
  end
`endif

endmodule

// File: doc/execute_stage_reg.md
Name: execute_stage_reg

Overview:
- Decode→Execute pipeline register plus the Execute-stage operand-forwarding muxes and ARM condition/flags unit.
- Consumes FlushE, ForwardAE and ForwardBE from the hazard unit.
- Returns RA1E, RA2E, WA3E and MemtoRegE to the hazard unit.
- Feeds the ALU and the Execute→Memory register.

Parameters:
WIDTH, 32, datapath width of register operands and immediates

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
FlushE  in  1  load a bubble into E next edge
RD1D, RD2D, ExtImmD  in  WIDTH each  decode operands and immediate
RA1D, RA2D, WA3D  in  4 each  register addresses
RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD, PCSrcD  in  1 each  decode control
ALUControlD  in  2  ALU op
FlagWriteD  in  2  [1]=NZ, [0]=CV update enables
CondD  in  4  ARM condition field
ForwardAE, ForwardBE  in  2 each  forwarding selects
ALUResultM, ResultW  in  WIDTH each  forwarding sources
ALUFlags  in  4  NZCV from ALU this cycle
RA1E, RA2E, WA3E  out  4 each  registered addresses to hazard unit
MemtoRegE  out  1  raw registered MemtoReg to hazard unit
SrcAE, SrcBE, WriteDataE  out  WIDTH each  ALU operands and store data
ALUControlE  out  2  registered ALU op
CondExE  out  1  condition passed
RegWriteGE, MemWriteGE, PCSrcGE, BranchTakenE  out  1 each  condition-gated controls
FlagsE  out  4  current NZCV register

Behaviour:
Reset:
- rst_n low asynchronously clears every E-register field and FlagsE to 0.
- Reset dominates FlushE.
- Combinational outputs after reset: CondExE=0 (Cond=0000 EQ with Z=0), gated controls 0, SrcAE=SrcBE=WriteDataE=0.

Pipeline register (each rising edge, no stall input; Execute never stalls):
- FlushE=1: all control fields = 0 (RegWrite, MemWrite, MemtoReg, ALUSrc, Branch, PCSrc, FlagWrite, ALUControl), Cond = 4'hF. RD1/RD2/ExtImm/RA1/RA2/WA3 = 0. Result is a bubble.
- FlushE=0: capture all D inputs.
- Latency D→E: 1 cycle.

Forwarding (combinational):
- ForwardAE selects SrcAE: 00 → RD1E, 01 → ResultW, 10 → ALUResultM, 11 → RD1E.
- ForwardBE selects WriteDataE with the same encoding over RD2E.
- SrcBE = ALUSrcE ? ExtImmE : WriteDataE.

Condition check (FlagsE = {N,Z,C,V}):
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
- 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F 0.

Gating:
- RegWriteGE = RegWriteE & CondExE
- MemWriteGE = MemWriteE & CondExE
- PCSrcGE = PCSrcE & CondExE
- BranchTakenE = BranchE & CondExE

Flags register:
- On the edge, if CondExE: FlagWriteE[1] loads N,Z from ALUFlags[3:2]; FlagWriteE[0] loads C,V from ALUFlags[1:0]. Fields not enabled hold.
- An instruction evaluates CondExE against flags before its own update. The next instruction in E sees the updated flags.
- A flush does not alter FlagsE directly; bubbles never write flags.

Mid-operation reset:
- The contents of E are discarded with no partial flag update.

Optional Feature:
- Macro: EXECUTE_BUBBLE_COUNT_EN.
- Defined: adds output BubbleCountE [31:0] plus a counter that increments on each edge where FlushE=1 and rst_n=1. The counter saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 with random D inputs and clock running → all E outputs 0, FlagsE=0, CondExE=0. Release, load CondD=E, RegWriteD=1 → next edge RegWriteGE=1.
- Forward A: RD1D=0x11, ForwardAE=10, ALUResultM=0xAA → SrcAE=0xAA. ForwardAE=01, ResultW=0xBB → 0xBB. ForwardAE=11 → 0x11.
- Forward B + imm: RD2D=0x22, ExtImmD=0x40, ALUSrcD=0, ForwardBE=01, ResultW=0x99 → SrcBE=WriteDataE=0x99. With ALUSrcD=1 → SrcBE=0x40, WriteDataE=0x99.
- Flush: load WA3D=6, MemtoRegD=1, RegWriteD=1 with FlushE=1 → next cycle WA3E=0, MemtoRegE=0, RegWriteGE=0, CondExE=0.
- Conditional: CMP in E with CondD=E, FlagWriteD=11, ALUFlags=0100 → FlagsE=0100. Following instruction CondD=0 (EQ), MemWriteD=1 → MemWriteGE=1. Then CondD=1 (NE) → MemWriteGE=0. Partial FlagWriteD=01 with ALUFlags=1011 → FlagsE=0111.
- With EXECUTE_BUBBLE_COUNT_EN: 3 flush cycles → BubbleCountE=3. Assert rst_n=0 → 0.
